// File: rtl/mem_requester.sv
// mem_requester: valid/ready front end owning address, write and read-capture timing of a 2R1W register memory.
// Define MEM_REQUESTER_STATS_EN to add saturating rd_count/wr_count outputs.
module mem_requester #(
  parameter int DEPTH = 32,
  parameter int BITS = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr_a,
  input  logic [AW-1:0]   req_addr_b,
  input  logic [BITS-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [BITS-1:0] rsp_data_a,
  output logic [BITS-1:0] rsp_data_b,
  output logic [AW-1:0]   mem_address1,
  output logic [AW-1:0]   mem_address2,
  output logic [AW-1:0]   mem_addressw,
  output logic [BITS-1:0] mem_writeData,
  output logic            mem_writeEn,
  input  logic [BITS-1:0] mem_read1,
  input  logic [BITS-1:0] mem_read2
`ifdef MEM_REQUESTER_STATS_EN
  ,
  output logic [15:0]     rd_count,
  output logic [15:0]     wr_count
`endif
);
  localparam logic [1:0] IDLE = 2'd0, CAPTURE = 2'd1, HOLD = 2'd2;
  logic [1:0]      r_state;
  logic [AW-1:0]   r_addr_a, r_addr_b;
  logic            r_oor_a, r_oor_b;
  logic [BITS-1:0] r_hold_a, r_hold_b;
  logic            w_idle, w_busy, w_wr_acc, w_rd_acc, w_oor_a, w_oor_b;
  logic [BITS-1:0] w_cap_a, w_cap_b;
  logic [1:0]      w_next;
  assign w_idle   = rst_n && r_state == IDLE;
  assign w_busy   = r_state == CAPTURE || r_state == HOLD;
  assign w_oor_a  = int'(req_addr_a) >= DEPTH;
  assign w_oor_b  = int'(req_addr_b) >= DEPTH;
  assign w_wr_acc = w_idle && req_valid && req_write;
  assign w_rd_acc = w_idle && req_valid && !req_write;
  // out-of-range lanes read as zero rather than whatever the array aliases to
  assign w_cap_a  = r_oor_a ? '0 : mem_read1;
  assign w_cap_b  = r_oor_b ? '0 : mem_read2;
  assign w_next   = w_rd_acc ? CAPTURE : (w_busy && !rsp_ready) ? HOLD : IDLE;
  assign req_ready     = w_idle;
  assign rsp_valid     = rst_n && w_busy;
  assign mem_writeEn   = w_wr_acc && !w_oor_a;
  assign mem_addressw  = req_addr_a;
  assign mem_writeData = req_wdata;
  assign mem_address1  = r_state == IDLE ? req_addr_a : r_addr_a;
  assign mem_address2  = r_state == IDLE ? req_addr_b : r_addr_b;
  assign rsp_data_a    = !rst_n ? '0 : r_state == CAPTURE ? w_cap_a : r_state == HOLD ? r_hold_a : '0;
  assign rsp_data_b    = !rst_n ? '0 : r_state == CAPTURE ? w_cap_b : r_state == HOLD ? r_hold_b : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_oor_a  <= 1'b0;
      r_oor_b  <= 1'b0;
      r_hold_a <= '0;
      r_hold_b <= '0;
    end else begin
      r_state <= w_next;
      if (w_rd_acc) begin
        r_addr_a <= req_addr_a;
        r_addr_b <= req_addr_b;
        r_oor_a  <= w_oor_a;
        r_oor_b  <= w_oor_b;
      end
      if (r_state == CAPTURE && !rsp_ready) begin
        r_hold_a <= w_cap_a;
        r_hold_b <= w_cap_b;
      end
    end
  end
`ifdef MEM_REQUESTER_STATS_EN
  logic [15:0] r_rd_count, r_wr_count;
  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_rd_acc && r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
      if (w_wr_acc && r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_requester.sv
// tb_mem_requester: directed checks of mem_requester against a behavioural 2R1W memory, DEPTH=20.
module tb_mem_requester;
  localparam int DEPTH = 20;
  localparam int BITS = 64;
  localparam int AW = $clog2(DEPTH);
  logic            clk = 1'b0;
  logic            rst_n, req_valid, req_ready, req_write, rsp_valid, rsp_ready, mem_writeEn;
  logic [AW-1:0]   req_addr_a, req_addr_b, mem_address1, mem_address2, mem_addressw;
  logic [BITS-1:0] req_wdata, rsp_data_a, rsp_data_b, mem_writeData;
  logic [BITS-1:0] mem_read1 = '0, mem_read2 = '0;
  logic [BITS-1:0] mem [0:31];
  int n_chk = 0, n_fail = 0;
  mem_requester #(.DEPTH(DEPTH), .BITS(BITS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr_a(req_addr_a), .req_addr_b(req_addr_b),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .mem_address1(mem_address1),
    .mem_address2(mem_address2), .mem_addressw(mem_addressw), .mem_writeData(mem_writeData),
    .mem_writeEn(mem_writeEn), .mem_read1(mem_read1), .mem_read2(mem_read2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    mem_read1 <= mem[mem_address1];
    mem_read2 <= mem[mem_address2];
  end
  always @(negedge clk) if (mem_writeEn) mem[mem_addressw] = mem_writeData;
  task automatic check(input string tag, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic v, input logic w, input int a, input int b, input logic [BITS-1:0] d);
    req_valid = v;
    req_write = w;
    req_addr_a = AW'(a);
    req_addr_b = AW'(b);
    req_wdata = d;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    req(1'b1, 1'b1, 3, 0, 64'h99);
    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_wen", 64'(mem_writeEn), 64'd0);
      check("rst_rsp_a", rsp_data_a, 64'd0);
    end
    check("rst_no_write", mem[3], 64'd0);
    rst_n = 1'b1;
    req(1'b1, 1'b1, 3, 0, 64'hAAAA);
    #1;
    check("wr1_ready", 64'(req_ready), 64'd1);
    check("wr1_wen", 64'(mem_writeEn), 64'd1);
    check("wr1_addrw", 64'(mem_addressw), 64'd3);
    tick();
    req(1'b1, 1'b1, 4, 0, 64'h5555);
    #1;
    check("wr2_ready", 64'(req_ready), 64'd1);
    check("wr2_wen", 64'(mem_writeEn), 64'd1);
    check("wr2_rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    req(1'b1, 1'b1, 7, 0, 64'h1234);
    #1;
    check("wr_no_rsp", 64'(rsp_valid), 64'd0);
    check("mem3", mem[3], 64'hAAAA);
    check("mem4", mem[4], 64'h5555);
    tick();
    req(1'b1, 1'b0, 7, 0, 64'h0);
    #1;
    check("rd_accept_ready", 64'(req_ready), 64'd1);
    check("rd_accept_wen", 64'(mem_writeEn), 64'd0);
    tick();
    req(1'b0, 1'b0, 0, 0, 64'h0);
    rsp_ready = 1'b1;
    #1;
    check("wtr_valid", 64'(rsp_valid), 64'd1);
    check("wtr_data_a", rsp_data_a, 64'h1234);
    check("wtr_data_b", rsp_data_b, 64'd0);
    check("wtr_ready", 64'(req_ready), 64'd0);
    tick();
    #1;
    check("wtr_done_valid", 64'(rsp_valid), 64'd0);
    check("wtr_done_ready", 64'(req_ready), 64'd1);
    req(1'b1, 1'b1, 2, 0, 64'h2222);
    tick();
    req(1'b1, 1'b1, 5, 0, 64'h5005);
    tick();
    req(1'b1, 1'b0, 2, 5, 64'h0);
    rsp_ready = 1'b0;
    tick();
    req(1'b1, 1'b0, 9, 9, 64'h0);
    mem[2] = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_data_a", rsp_data_a, 64'h2222);
      check("bp_data_b", rsp_data_b, 64'h5005);
      check("bp_ready", 64'(req_ready), 64'd0);
      tick();
    end
    rsp_ready = 1'b1;
    req(1'b0, 1'b0, 0, 0, 64'h0);
    #1;
    check("bp_release_a", rsp_data_a, 64'h2222);
    tick();
    #1;
    check("bp_idle_valid", 64'(rsp_valid), 64'd0);
    check("bp_idle_ready", 64'(req_ready), 64'd1);
    req(1'b1, 1'b0, 5, 4, 64'h0);
    rsp_ready = 1'b0;
    tick();
    req(1'b0, 1'b0, 0, 0, 64'h0);
    tick();
    #1;
    check("hold_valid", 64'(rsp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("hold_rst_valid", 64'(rsp_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("post_rst_valid", 64'(rsp_valid), 64'd0);
    check("post_rst_ready", 64'(req_ready), 64'd1);
    tick();
    #1;
    check("post_rst_valid2", 64'(rsp_valid), 64'd0);
    req(1'b1, 1'b1, 1, 0, 64'h1111);
    tick();
    req(1'b1, 1'b1, 25, 0, 64'hBEEF);
    #1;
    check("oor_wen", 64'(mem_writeEn), 64'd0);
    check("oor_wr_ready", 64'(req_ready), 64'd1);
    tick();
    check("oor_mem25", mem[25], 64'd0);
    mem[25] = 64'hFFFF;
    req(1'b1, 1'b0, 25, 1, 64'h0);
    rsp_ready = 1'b1;
    tick();
    req(1'b0, 1'b0, 0, 0, 64'h0);
    #1;
    check("oor_rsp_valid", 64'(rsp_valid), 64'd1);
    check("oor_rsp_a", rsp_data_a, 64'd0);
    check("oor_rsp_b", rsp_data_b, 64'h1111);
    tick();
    #1;
    check("oor_idle", 64'(req_ready), 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
